// File: rtl/instr_feeder.sv
// Instruction feeder: fetches program words from a 1-cycle-latency synchronous memory,
// presents them on the processor DIN with Run, and advances the PC on Done.
module instr_feeder #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i,
    output logic [DW-1:0] din_o,
    output logic          run_o,
    input  logic          done_i,
    output logic          halted_o,
    output logic [AW-1:0] pc_o,
    output logic [CW-1:0] instr_count_o
);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FI,
        S_LI,
        S_LM,
        S_CM,
        S_EX,
        S_IM,
        S_WD,
        S_HALT
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] word0_q, word0_d;
    logic [DW-1:0] word1_q, word1_d;
    logic          run_q, run_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          is_mvi_c;
    logic [AW-1:0] next_pc_c;
    logic [2:0]    fetch_op_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            mem_addr_q <= '0;
            din_q      <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
            run_q      <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            din_q      <= din_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            run_q      <= run_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        din_d      = din_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        run_d      = run_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        is_mvi_c   = (word0_q[8:6] == OP_MVI);
        next_pc_c  = is_mvi_c ? pc_q + AW'(2) : pc_q + AW'(1);
        fetch_op_c = mem_data_i[8:6];

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FI;
                    mem_addr_d = pc_q;
                end
            end
            S_FI: state_d = S_LI;
            S_LI: begin
                word0_d = mem_data_i;
                if (fetch_op_c == OP_HALT) begin
                    state_d  = S_HALT;
                    run_d    = 1'b0;
                    halted_d = 1'b1;
                    din_d    = '0;
                end else if (fetch_op_c == OP_MVI) begin
                    state_d    = S_LM;
                    mem_addr_d = pc_q + AW'(1);
                end else begin
                    state_d = S_EX;
                    din_d   = mem_data_i;
                    run_d   = 1'b1;
                end
            end
            S_LM: state_d = S_CM;
            S_CM: begin
                word1_d = mem_data_i;
                state_d = S_EX;
                din_d   = word0_q;
                run_d   = 1'b1;
            end
            S_EX: begin
                if (!done_i && is_mvi_c) begin
                    state_d = S_IM;
                    din_d   = word1_q;
                end else if (!done_i) begin
                    state_d = S_WD;
                end
            end
            S_IM: begin
                if (!done_i) begin
                    state_d = S_WD;
                end
            end
            S_WD: ;
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        // Done retires the live instruction from EX, IM or WD alike
        if ((state_q == S_EX || state_q == S_IM || state_q == S_WD) && done_i) begin
            state_d    = S_FI;
            pc_d       = next_pc_c;
            mem_addr_d = next_pc_c;
            cnt_d      = cnt_q + CW'(1);
            run_d      = 1'b0;
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign din_o         = din_q;
    assign run_o         = run_q;
    assign halted_o      = halted_q;
    assign pc_o          = pc_q;
    assign instr_count_o = cnt_q;

endmodule
